// File: rtl/g2b_conv.sv
// Registered Gray-to-binary converter with a one-word valid/ready output slot.
// Define G2B_DIR_EN to add a per-word dir input (1 = binary-to-Gray).
module g2b_conv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef G2B_DIR_EN
  ,
  input  logic             dir
`endif
);

  logic [WIDTH-1:0] g2b_w;
  logic [WIDTH-1:0] b2g_w;
  logic [WIDTH-1:0] conv_w;
  logic             accept;

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray bits above and at it.
  always_comb begin : g2b_calc
    logic acc;
    acc   = 1'b0;
    g2b_w = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ in[i];
      g2b_w[i] = acc;
    end
  end

  assign b2g_w = in ^ (in >> 1);

`ifdef G2B_DIR_EN
  assign conv_w = dir ? b2g_w : g2b_w;
`else
  assign conv_w = g2b_w;
`endif

  // Handshake: a word moves on any edge where valid && ready; the slot is free
  // when empty or draining this cycle, so in_ready is the only comb in->out path.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= conv_w;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_g2b_conv.sv
// Bench for g2b_conv: queue-based reference model checked every cycle plus
// directed literal checks (4-bit sweep, backpressure, 8-bit boundaries).
module tb_g2b_conv;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_w, out_w;
  logic         dir;

  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]   in8, out8;

  g2b_conv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_w)
`ifdef G2B_DIR_EN
    , .dir(dir)
`endif
  );

  g2b_conv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in(in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8)
`ifdef G2B_DIR_EN
    , .dir(1'b0)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversions written as whole-word arithmetic.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Model: the slot is a queue of at most one converted word.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;
  logic         m_acc, m_drn, m_dir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      last_out = '0;
    end else begin
`ifdef G2B_DIR_EN
      m_dir = dir;
`else
      m_dir = 1'b0;
`endif
      m_drn = (exp_q.size() != 0) && out_ready;
      m_acc = in_valid && ((exp_q.size() == 0) || out_ready);
      if (m_drn) begin
        last_out = exp_q[0];
        void'(exp_q.pop_front());
      end
      if (m_acc) exp_q.push_back(m_dir ? ref_b2g(in_w) : ref_g2b(in_w));
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("model_out", 32'(out_w), 32'((exp_q.size() != 0) ? exp_q[0] : last_out));
    check("model_in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gray_tab[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [7:0] g8_in[3]  = '{8'h80, 8'h00, 8'hC0};
  logic [7:0] g8_exp[3] = '{8'hFF, 8'h00, 8'h80};

  initial begin
    in_valid = 1'b0; in_w = '0; out_ready = 1'b0; dir = 1'b0;
    in_valid8 = 1'b0; in8 = '0; out_ready8 = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_out", 32'(out_w), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Full 4-bit Gray sweep at one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_w = gray_tab[i];
      tick();
      check("sweep_out", 32'(out_w), i);
      check("sweep_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: hold 1100 for three stalled cycles, ignoring new input
    in_valid = 1'b1; in_w = 4'b1010;
    tick();
    check("bp_load", 32'(out_w), 32'b1100);
    in_w = 4'b0001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_out", 32'(out_w), 32'b1100);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'h0);
    check("bp_drain_out", 32'(out_w), 32'b1100);
    in_valid = 1'b1; in_w = 4'b0111;
    tick();
    check("bp_next_out", 32'(out_w), 32'b0101);

    // Simultaneous drain and accept
    in_w = 4'b1000;
    tick();
    check("da_out", 32'(out_w), 32'b1111);
    check("da_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    tick();

`ifdef G2B_DIR_EN
    in_valid = 1'b1; dir = 1'b1; in_w = 4'b1011;
    tick();
    check("b2g_1011", 32'(out_w), 32'b1110);
    for (int v = 0; v < 16; v++) begin
      dir = 1'b1; in_w = 4'(v);
      tick();
      dir = 1'b0; in_w = out_w;
      tick();
      check("round_trip", 32'(out_w), v);
    end
    in_valid = 1'b0; dir = 1'b0;
    tick();
`endif

    // WIDTH=8 boundaries
    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1; in8 = g8_in[i];
      tick();
      check("w8_out", 32'(out8), 32'(g8_exp[i]));
      check("w8_valid", 32'(out_valid8), 32'h1);
    end
    in_valid8 = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_w      = W'($urandom_range(0, (1 << W) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      dir       = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset while a word is held
    in_valid = 1'b1; in_w = 4'b1111; out_ready = 1'b0; dir = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_w), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_w = 4'b0010; out_ready = 1'b1;
    tick();
    check("post_rst_first", 32'(out_w), 32'b0011);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/g2b_conv.md
# g2b_conv

Registered Gray-code-to-binary converter with a single-stage valid/ready pipeline slot. It accepts a WIDTH-bit reflected Gray codeword and returns the equivalent unsigned binary value one clock later. It sits between a Gray-coded source, such as a CDC pointer or an encoder, and binary arithmetic logic. Optionally, a runtime direction input also allows binary-to-Gray conversion.

## Interface
- WIDTH, default 4: codeword width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present this cycle.
- in_ready  output  1  slot can accept a word this cycle.
- in  input  WIDTH  input codeword (Gray; binary when dir=1).
- out_valid  output  1  out holds a converted word.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  WIDTH  converted word.
- dir  input  1  direction select (0 = Gray to binary, 1 = binary to Gray); present only when G2B_DIR_EN is defined.

## Operation
- Gray to binary conversion: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] ^ in[i] for i = WIDTH-2 down to 0. This is the prefix XOR from the MSB.
- Binary to Gray conversion (dir=1): out[i] = in[i] ^ in[i+1]; the MSB passes through.
- Conversion is purely combinational. Its result is captured into a single output register with its valid flag.
- Acceptance: a word is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This allows full throughput, with a new word loaded in the same cycle the old word drains.
- Accept with no drain: the output register loads the converted word and out_valid is set.
- Drain (out_valid && out_ready) with no accept: out_valid clears and out holds its last value.
- Accept and drain in the same cycle: the new word replaces the old one and out_valid stays 1.
- Stall (out_valid && !out_ready): out and out_valid hold, and in_ready = 0. in is ignored.
- dir is sampled together with in at acceptance. A change to dir while stalled has no effect on the held word.
- No illegal codewords exist: every WIDTH-bit value maps one-to-one, including all-ones and the wrap from max to 0.

## Timing
- Reset (rst_n low, asynchronous): out = 0 and out_valid = 0 immediately, so in_ready = 1.
- Reset release is synchronous to the clk rising edge. The first accept can occur on the first edge after deassertion.
- A word accepted at edge N appears on out with out_valid=1 after edge N, a latency of 1 cycle.
- Sustained throughput is 1 word per cycle while out_ready=1.
- Reset mid-operation: any held word is discarded and no partial output appears.
- in_ready has a combinational path from out_ready. No other combinational path runs from input to output.

## Configuration
- G2B_DIR_EN defined: the dir port exists and both directions are supported per word.
- G2B_DIR_EN undefined: no dir port and Gray-to-binary conversion only.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out=0, out_valid=0, and in_ready=1 immediately, without waiting for a clock.
- Full 4-bit sweep, WIDTH=4, out_ready=1, one word per cycle. Inputs 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 -> out 0000..1111 in order, each one cycle after its input.
- Backpressure: accept Gray 1010, then hold out_ready=0 for 3 cycles -> out=1100 is held, out_valid=1, in_ready=0, and new inputs are ignored. Release -> 1100 drains, then the next word follows.
- Simultaneous drain and accept: with out_valid=1 and out_ready=1, present Gray 1000 -> out=1111 next cycle and out_valid stays 1.
- WIDTH=8 boundaries: Gray 0x80 -> 0xFF, 0x00 -> 0x00, 0xC0 -> 0x80.
- With G2B_DIR_EN defined, dir=1: binary 1011 -> Gray 1110. Round-trip every 4-bit value through b2g then g2b -> the original value.
